uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//   UART transmit sequencer. Accepts one byte per valid/ready handshake and serialises it LSB-first.
//   Frame order: start bit, 8 data bits, optional parity bit, stop bit(s).
//   Sits between the byte source (CPU/FIFO) and the TX pin. Parity is computed on the byte latched at acceptance.
// PARAMETERS
//   CLK_FREQ  50_000_000  system clock frequency, Hz
//   BAUD      115_200     line rate, bit/s
//   (localparam) CLKS_PER_BIT = CLK_FREQ/BAUD; must be >= 2; counter width = $clog2(CLKS_PER_BIT)
// PORTS
//   clk          in   1  system clock, all logic on rising edge
//   rst          in   1  synchronous, active-high reset
//   tx_valid     in   1  byte available on tx_data
//   tx_data      in   8  byte to send
//   parity_type  in   2  00 none; x1 odd (bit = ~^data); 10 even (bit = ^data)
//   tx_ready     out  1  high only in IDLE; transfer occurs when tx_valid & tx_ready
//   tx_serial    out  1  serial line, idles high
//   tx_busy      out  1  high from the cycle after acceptance until the end of the frame
//   tx_done      out  1  one-cycle pulse when a frame completes
// BEHAVIOUR
//   Reset values: tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, FSM=IDLE, counters=0.
//   FSM: IDLE -> START -> DATA -> PARITY (skipped when parity_type==00) -> STOP -> IDLE.
//   Accept: in IDLE with tx_valid=1, latch tx_data and parity_type. Later input changes are ignored until the next IDLE.
//   Start bit is driven from the cycle after acceptance (latency 1). Each bit lasts exactly CLKS_PER_BIT cycles.
//   DATA: bit index 0..7 (LSB first); advance when the baud counter reaches CLKS_PER_BIT-1.
//     Move to PARITY or STOP after bit 7.
//   PARITY: bit computed from the latched byte/type. Encoding 2'b11 behaves as odd.
//   STOP: tx_serial=1 for 1 bit period (2 with the macro below). Then go to IDLE.
//   tx_done pulses in the first IDLE cycle. tx_ready is also 1 in that cycle.
//     A back-to-back accept in that cycle starts the next start bit one cycle later (no idle gap beyond 1 cycle).
//   Frame length: (10 + P + S2) * CLKS_PER_BIT cycles. P=1 when parity is enabled; S2=1 with the macro.
//   rst mid-frame: frame abandoned, next edge gives tx_serial=1 and IDLE, no tx_done.
//   Baud counter restarts at 0 on every state change; no drift accumulates across bits.
// CONFIGURATION
//   UART_TX_STOP2_EN defined: STOP lasts 2 bit periods (two stop bits).
//   Undefined: STOP lasts 1 bit period. The port list is unchanged in both cases.
// STRUCTURE
//   uart_pkg: parity_type encodings (PAR_NONE=2'b00, PAR_EVEN=2'b10, odd = bit0 set);
//     FSM state encoding (IDLE, START, DATA, PARITY, STOP).
//   One sub-module: uart_baud_gen. Bit-period counter with a clear input; emits a tick at CLKS_PER_BIT-1.
//   Shared later by uart_rx_ctrl.
//   Parity is an inline reduction XOR on the latched byte.
// TESTING  (CLK_FREQ=4, BAUD=1 -> CLKS_PER_BIT=4; sample mid-bit)
//   1. Reset held 3 cycles -> tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0.
//   2. tx_data=8'hA5, parity=01 -> line 0,1,0,1,0,0,1,0,1,P=1,1. 44 cycles; tx_done 1 pulse.
//   3. tx_data=8'h07: parity=10 -> P=1; parity=11 -> P=0; parity=00 -> no P bit, frame 40 cycles.
//   4. Back-to-back: tx_valid held high, bytes 8'h55 then 8'hAA.
//      Second start bit begins 1 cycle after the tx_done pulse. tx_data changed mid-frame does not corrupt the frame.
//   5. rst asserted in DATA bit 3 -> next cycle tx_serial=1, tx_ready=1, no tx_done.
//      A new frame then sends cleanly.
//   6. With UART_TX_STOP2_EN: 8'hA5, parity=01 -> stop high 8 cycles, total 48 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity_type encodings and TX sequencer state codes.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: ticks on the last cycle of each CLKS_PER_BIT period, restarts on clear.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, 8 data bits LSB-first, optional parity, stop bit(s).
// Define UART_TX_STOP2_EN to send two stop bits instead of one.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic [1:0] parity_type,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

`ifdef UART_TX_STOP2_EN
    localparam logic STOP_LAST = 1'b1;
`else
    localparam logic STOP_LAST = 1'b0;
`endif

    logic [2:0] state;
    logic [2:0] next_state;
    logic [7:0] data_q;
    logic [1:0] ptype_q;
    logic [2:0] bit_idx;
    logic       stop_idx;
    logic       done_q;
    logic       tick;
    logic       clear;

    // Counter is held cleared in IDLE and on every transition so each bit starts fresh.
    assign clear = (state == ST_IDLE) || (next_state != state);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (tx_valid) next_state = ST_START;
            ST_START:  if (tick) next_state = ST_DATA;
            ST_DATA:   if (tick && bit_idx == 3'd7)
                           next_state = (ptype_q == PAR_NONE) ? ST_STOP : ST_PARITY;
            ST_PARITY: if (tick) next_state = ST_STOP;
            ST_STOP:   if (tick && stop_idx == STOP_LAST) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            data_q   <= '0;
            ptype_q  <= PAR_NONE;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= (state == ST_STOP) && (next_state == ST_IDLE);
            if (state == ST_IDLE && tx_valid) begin
                data_q  <= tx_data;
                ptype_q <= parity_type;
            end
            if (state != ST_DATA) begin
                bit_idx <= '0;
            end else if (tick) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (state != ST_STOP) begin
                stop_idx <= 1'b0;
            end else if (tick && next_state == ST_STOP) begin
                stop_idx <= 1'b1;
            end
        end
    end

    always_comb begin
        tx_serial = 1'b1;
        case (state)
            ST_START:  tx_serial = 1'b0;
            ST_DATA:   tx_serial = data_q[bit_idx];
            ST_PARITY: tx_serial = ptype_q[0] ? ~^data_q : ^data_q;
            default:   tx_serial = 1'b1;
        endcase
    end

    assign tx_ready = (state == ST_IDLE);
    assign tx_busy  = (state != ST_IDLE);
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl at CLKS_PER_BIT=4; honours UART_TX_STOP2_EN.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic [1:0] parity_type = '0;
    logic       tx_ready;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic        exp_q[$];

`ifdef UART_TX_STOP2_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    uart_tx_ctrl #(
        .CLK_FREQ(4),
        .BAUD    (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .parity_type(parity_type),
        .tx_ready   (tx_ready),
        .tx_serial  (tx_serial),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Builds the expected line sequence; returns the frame length in bits.
    task automatic push_frame(input logic [7:0] d, input logic [1:0] pt, output int nbits);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        nbits = 9 + NSTOP;
        if (pt != 2'b00) begin
            exp_q.push_back(pt[0] ? ~^d : ^d);
            nbits++;
        end
        for (int i = 0; i < NSTOP; i++) exp_q.push_back(1'b1);
    endtask

    task automatic check_bit(input int n);
        logic e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL bit n=%0d: got %b, scoreboard empty", n, tx_serial);
        end else begin
            e = exp_q.pop_front();
            if (tx_serial !== e) begin
                miscompares++;
                $display("FAIL bit n=%0d: got %b, expected %b", n, tx_serial, e);
            end
        end
    endtask

    // Presents a byte, then follows the frame through to the tx_done cycle.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input bit keep_valid);
        int nbits;
        int last;
        push_frame(d, pt, nbits);
        last = nbits * 4 + 1;
        tx_valid = 1'b1;
        tx_data = d;
        parity_type = pt;
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_before_accept: got %b, expected 1", tx_ready);
        end
        step();
        if (!keep_valid) tx_valid = 1'b0;
        tx_data = 8'($urandom);
        parity_type = 2'($urandom);
        for (int n = 1; n <= last; n++) begin
            if (n > 1) step();
            if (n == 3) tx_data = ~d;
            if (n < last) begin
                vectors++;
                if (tx_busy !== 1'b1 || tx_ready !== 1'b0 || tx_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL in_frame n=%0d: busy/ready/done %b%b%b, expected 100",
                             n, tx_busy, tx_ready, tx_done);
                end
                if ((n - 2) % 4 == 0) check_bit(n);
            end else begin
                vectors++;
                if (tx_done !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_serial !== 1'b1) begin
                    miscompares++;
                    $display("FAIL frame_end n=%0d: done/ready/busy/serial %b%b%b%b, expected 1101",
                             n, tx_done, tx_ready, tx_busy, tx_serial);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_bits: got %0d, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic idle_check(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            step();
            vectors++;
            if (tx_serial !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s: serial/ready/busy/done %b%b%b%b, expected 1100",
                         name, tx_serial, tx_ready, tx_busy, tx_done);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_valid = 1'b1;
        repeat (3) step();
        vectors++;
        if (tx_serial !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: serial/ready/busy/done %b%b%b%b, expected 1100",
                     tx_serial, tx_ready, tx_busy, tx_done);
        end
        tx_valid = 1'b0;
        rst = 1'b0;
        idle_check(2, "idle_after_reset");
    endtask

    task automatic test_parity();
        send_frame(8'hA5, 2'b01, 1'b0);
        idle_check(2, "idle_a5");
        send_frame(8'h07, 2'b10, 1'b0);
        idle_check(1, "idle_07_even");
        send_frame(8'h07, 2'b11, 1'b0);
        idle_check(1, "idle_07_odd11");
        send_frame(8'h07, 2'b00, 1'b0);
        idle_check(3, "idle_07_none");
    endtask

    task automatic test_back_to_back();
        send_frame(8'h55, 2'b10, 1'b1);
        send_frame(8'hAA, 2'b01, 1'b1);
        send_frame(8'h3C, 2'b00, 1'b0);
        idle_check(2, "idle_b2b");
    endtask

    task automatic test_reset_mid_frame();
        int nbits;
        push_frame(8'hC3, 2'b01, nbits);
        tx_valid = 1'b1;
        tx_data = 8'hC3;
        parity_type = 2'b01;
        step();
        tx_valid = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            if (n > 1) step();
            if ((n - 2) % 4 == 0) check_bit(n);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        vectors++;
        if (tx_serial !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_frame: serial/ready/done %b%b%b, expected 110",
                     tx_serial, tx_ready, tx_done);
        end
        idle_check(8, "idle_after_abort");
        send_frame(8'h96, 2'b10, 1'b0);
        idle_check(2, "idle_final");
    endtask

    initial begin
        test_reset();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
